// File: rtl/tlb_lru_update_if.sv
// Touch handshake between a TLB access requester and the LRU recency tracker.
// The requester drives touch_valid/touch_way and holds them until touch_ready.
interface tlb_lru_update_if #(
  parameter int NUM_WAYS = 4
);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic             touch_valid;
  logic [WAY_W-1:0] touch_way;
  logic             touch_ready;

  modport master (output touch_valid, output touch_way, input touch_ready);
  modport slave  (input touch_valid, input touch_way, output touch_ready);
endinterface

// File: rtl/tlb_lru_update.sv
// Per-way recency counters for TLB victim selection, with one-cycle renormalisation on saturation.
// Optional macro TLB_LRU_STATS_EN adds a saturating 16-bit renormalisation event counter.
module tlb_lru_update #(
  parameter int NUM_WAYS = 4,
  parameter int LRU_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  tlb_lru_update_if.slave     touch,
  input  logic                flush,
  output logic [LRU_BITS-1:0] lru_count [NUM_WAYS],
  output logic                busy
`ifdef TLB_LRU_STATS_EN
  ,
  output logic [15:0]         renorm_count
`endif
);

  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [LRU_BITS-1:0] CNT_MAX  = '1;
  localparam logic [LRU_BITS-1:0] CNT_ONE  = LRU_BITS'(1);
  localparam logic [WAY_W:0]      RANK_ONE = (WAY_W + 1)'(1);

  typedef enum logic {IDLE, RENORM} state_e;

  state_e              state_q, state_d;
  logic [WAY_W-1:0]    pending_q, pending_d;
  logic [LRU_BITS-1:0] cnt_q [NUM_WAYS];
  logic [LRU_BITS-1:0] cnt_d [NUM_WAYS];

  logic [LRU_BITS-1:0] max_cnt;
  logic [WAY_W:0]      num_max;
  logic [WAY_W:0]      rank [NUM_WAYS];
  logic                touch_fire;
  logic                way_is_top;
  logic                saturated;

  // Max, tie count at the max, and a strict ranking where equal values
  // order by index so the lower way is treated as older.
  always_comb begin
    // NOTE: blocking assignments here are intentional; each loop iteration reads the value the previous one produced.
    max_cnt = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (cnt_q[i] > max_cnt) max_cnt = cnt_q[i];
    end
    num_max = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (cnt_q[i] == max_cnt) num_max = num_max + RANK_ONE;
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_WAYS; j++) begin
        if ((cnt_q[j] < cnt_q[i]) || ((cnt_q[j] == cnt_q[i]) && (j < i)))
          rank[i] = rank[i] + RANK_ONE;
      end
    end
  end

  assign touch_fire = touch.touch_valid && touch.touch_ready;
  assign way_is_top = (cnt_q[touch.touch_way] == max_cnt) && (num_max == RANK_ONE);
  assign saturated  = (max_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    pending_d = pending_q;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (touch_fire && saturated && !way_is_top) begin
            state_d   = RENORM;
            pending_d = touch.touch_way;
          end
        end
        RENORM: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    touch.touch_ready = (state_q == IDLE) && !flush;
    busy              = (state_q == RENORM);
  end

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) cnt_d[i] = cnt_q[i];
    if (flush) begin
      for (int i = 0; i < NUM_WAYS; i++) cnt_d[i] = '0;
    end else if (state_q == RENORM) begin
      for (int i = 0; i < NUM_WAYS; i++) cnt_d[i] = LRU_BITS'(rank[i]);
      cnt_d[pending_q] = LRU_BITS'(NUM_WAYS);
    end else if (touch_fire && !saturated && !way_is_top) begin
      cnt_d[touch.touch_way] = max_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counters are a small flop bank, not a RAM, so resetting every entry is intended.
      for (int i = 0; i < NUM_WAYS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign lru_count = cnt_q;

`ifdef TLB_LRU_STATS_EN
  logic [15:0] renorm_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      renorm_cnt_q <= '0;
    end else if (flush) begin
      renorm_cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == RENORM) && (renorm_cnt_q != 16'hFFFF)) begin
      renorm_cnt_q <= renorm_cnt_q + 16'd1;
    end
  end

  assign renorm_count = renorm_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_lru_update.sv
// Directed bench for tlb_lru_update: touches, saturation/renormalisation, flush and reset.
// Build with TLB_LRU_STATS_EN defined to also exercise renorm_count.
module tb_tlb_lru_update;
  localparam int NW = 4;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [LB-1:0] lru_count [NW];
  logic busy;
`ifdef TLB_LRU_STATS_EN
  logic [15:0] renorm_count;
`endif

  int checks = 0;
  int errors = 0;

  tlb_lru_update_if #(.NUM_WAYS(NW)) tif ();

  tlb_lru_update #(.NUM_WAYS(NW), .LRU_BITS(LB)) dut (
    .clk         (clk),
    .rst         (rst),
    .touch       (tif.slave),
    .flush       (flush),
    .lru_count   (lru_count),
    .busy        (busy)
`ifdef TLB_LRU_STATS_EN
    ,
    .renorm_count(renorm_count)
`endif
  );

  always #5 clk = ~clk;

  // Packs expected counters given in way0..way3 order.
  function automatic logic [15:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [15:0] cnt_now();
    return {lru_count[3], lru_count[2], lru_count[1], lru_count[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted touch; waits a bounded number of cycles for touch_ready.
  task automatic touch(input int way);
    bit done = 1'b0;
    tif.touch_valid = 1'b1;
    tif.touch_way   = 2'(way);
    for (int k = 0; k < 8 && !done; k++) begin
      if (tif.touch_ready) done = 1'b1;
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL touch_timeout: way %0d never accepted, required acceptance within 8 cycles", way);
    end
    tif.touch_valid = 1'b0;
  endtask

  task automatic touch_alt(input int n, input int wa, input int wb);
    for (int k = 0; k < n; k++) touch((k % 2 == 0) ? wa : wb);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    tif.touch_valid = 1'b0;
    tif.touch_way = '0;
    repeat (2) step();
    checks++;
    if (cnt_now() !== 16'h0000) begin
      errors++; $display("FAIL reset_counts: got %h want %h", cnt_now(), 16'h0000);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tif.touch_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", tif.touch_ready);
    end
  endtask

  task automatic test_single_touch();
    touch(2);
    checks++;
    if (cnt_now() !== pk(0, 0, 1, 0)) begin
      errors++; $display("FAIL single_touch: got %h want %h", cnt_now(), pk(0, 0, 1, 0));
    end
    checks++;
    if (tif.touch_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b want 1", tif.touch_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    for (int w = 0; w < NW; w++) touch(w);
    checks++;
    if (cnt_now() !== pk(1, 2, 3, 4)) begin
      errors++; $display("FAIL b2b_seq: got %h want %h", cnt_now(), pk(1, 2, 3, 4));
    end
    touch(3);
    checks++;
    if (cnt_now() !== pk(1, 2, 3, 4)) begin
      errors++; $display("FAIL b2b_top_retouch: got %h want %h", cnt_now(), pk(1, 2, 3, 4));
    end
  endtask

  // A touch held through RENORM must wait and apply afterwards.
  task automatic test_saturation();
    do_flush();
    touch_alt(11, 1, 2);
    touch(0); touch(2); touch(3); touch(1);
    checks++;
    if (cnt_now() !== pk(12, 15, 13, 14)) begin
      errors++; $display("FAIL sat_preload: got %h want %h", cnt_now(), pk(12, 15, 13, 14));
    end
    tif.touch_valid = 1'b1;
    tif.touch_way   = 2'd0;
    step();
    tif.touch_way   = 2'd3;
    checks++;
    if (busy !== 1'b1 || tif.touch_ready !== 1'b0) begin
      errors++; $display("FAIL sat_enter: busy %b ready %b want busy 1 ready 0", busy, tif.touch_ready);
    end
    checks++;
    if (cnt_now() !== pk(12, 15, 13, 14)) begin
      errors++; $display("FAIL sat_hold: got %h want %h", cnt_now(), pk(12, 15, 13, 14));
    end
    step();
    checks++;
    if (cnt_now() !== pk(4, 3, 1, 2) || busy !== 1'b0) begin
      errors++; $display("FAIL sat_renorm: got %h busy %b want %h busy 0", cnt_now(), busy, pk(4, 3, 1, 2));
    end
    step();
    tif.touch_valid = 1'b0;
    checks++;
    if (cnt_now() !== pk(4, 3, 1, 5)) begin
      errors++; $display("FAIL sat_stalled_touch: got %h want %h", cnt_now(), pk(4, 3, 1, 5));
    end
  endtask

  // Equal nonzero counts cannot be built through touches, so the tie case uses the zeros left by flush.
  task automatic test_tie_renorm();
    do_flush();
    touch_alt(15, 3, 2);
    checks++;
    if (cnt_now() !== pk(0, 0, 14, 15)) begin
      errors++; $display("FAIL tie_preload: got %h want %h", cnt_now(), pk(0, 0, 14, 15));
    end
    touch(1);
    step();
    checks++;
    if (cnt_now() !== pk(0, 4, 2, 3)) begin
      errors++; $display("FAIL tie_renorm: got %h want %h", cnt_now(), pk(0, 4, 2, 3));
    end
  endtask

  task automatic test_flush();
    do_flush();
    touch_alt(15, 3, 2);
    touch(0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_setup_busy: got %b want 1", busy);
    end
    do_flush();
    checks++;
    if (cnt_now() !== 16'h0000 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_in_renorm: got %h busy %b want 0000 busy 0", cnt_now(), busy);
    end
    flush = 1'b1;
    tif.touch_valid = 1'b1;
    tif.touch_way   = 2'd1;
    #1;
    checks++;
    if (tif.touch_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", tif.touch_ready);
    end
    step();
    flush = 1'b0;
    tif.touch_valid = 1'b0;
    checks++;
    if (cnt_now() !== 16'h0000) begin
      errors++; $display("FAIL flush_with_touch: got %h want 0000", cnt_now());
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    touch_alt(15, 3, 2);
    touch(1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_now() !== 16'h0000 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h busy %b want 0000 busy 0", cnt_now(), busy);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (cnt_now() !== 16'h0000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_drops_pending: got %h busy %b want 0000 busy 0", cnt_now(), busy);
    end
  endtask

`ifdef TLB_LRU_STATS_EN
  task automatic test_stats();
    do_flush();
    touch_alt(15, 3, 2);
    touch(0);
    step();
    for (int r = 0; r < 2; r++) begin
      touch_alt(11, 1, 2);
      touch(0);
      step();
    end
    checks++;
    if (renorm_count !== 16'd3) begin
      errors++; $display("FAIL stats_count: got %0d want 3", renorm_count);
    end
    do_flush();
    checks++;
    if (renorm_count !== 16'd0) begin
      errors++; $display("FAIL stats_flush: got %0d want 0", renorm_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_touch();
    test_back_to_back();
    test_saturation();
    test_tie_renorm();
    test_flush();
    test_async_reset();
`ifdef TLB_LRU_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
